// File: rtl/mem_responder.sv
// mem_responder: memory-module end of the system bus.
// Decodes the block number, runs one read or write on an external
// synchronous RAM (16 data + 1 parity bit) and answers OK / EN / PE
// with a four-phase handshake. Unselected requests are ignored.
module mem_responder #(
    parameter logic [3:0] MODULE_NB    = 4'd0,
    parameter int         AW           = 15,
    parameter int         READ_LATENCY = 1,
    parameter bit         PARITY_ODD   = 1'b1
) (
    input  logic          clk_sys,
    input  logic          clo_n,
    input  logic          rdr,
    input  logic          rdw,
    input  logic          rq,
    input  logic [0:3]    rnb,
    input  logic [0:15]   rad,
    input  logic [0:15]   rdt,
    output logic          dok,
    output logic          den,
    output logic          dpe,
    output logic [0:15]   ddt,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [0:16]   mem_d,
    input  logic [0:16]   mem_q,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_REPLY_OK,
        S_REPLY_EN,
        S_REPLY_PE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;

    logic [15:0] w_rad_le;
    logic        w_oor;
    logic [3:0]  w_eff_nb;
    logic        w_sel;
    logic        w_par_wr;
    logic        w_par_ok;

    // Address bits above the implemented width mark an absent word.
    assign w_rad_le = rad;
    assign w_oor    = |(w_rad_le >> AW);
    // A system-space requester (rq=0) always addresses block 0.
    assign w_eff_nb = rq ? rnb : 4'd0;
    assign w_sel    = (rdr ^ rdw) && (w_eff_nb == MODULE_NB);
    assign w_par_wr = (^rdt) ^ PARITY_ODD;
    assign w_par_ok = ((^mem_q) == PARITY_ODD);
    assign busy     = (r_state != S_IDLE);

    // Request decode, RAM access sequencing and reply handshake.
    always_ff @(posedge clk_sys or negedge clo_n) begin
        if (!clo_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 2'd0;
            dok     <= 1'b0;
            den     <= 1'b0;
            dpe     <= 1'b0;
            ddt     <= 16'h0000;
            mem_a   <= '0;
            mem_we  <= 1'b0;
            mem_d   <= 17'h00000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    mem_we <= 1'b0;
                    if (w_sel) begin
                        mem_a <= w_rad_le[AW-1:0];
                        if (w_oor) begin
                            den     <= 1'b1;
                            ddt     <= 16'h0000;
                            r_state <= S_REPLY_EN;
                        end else if (rdw) begin
                            mem_we  <= 1'b1;
                            mem_d   <= {rdt, w_par_wr};
                            r_state <= S_WRITE;
                        end else begin
                            r_cnt   <= 2'(READ_LATENCY);
                            r_state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    // The write is committed this cycle even if the
                    // initiator gives up; only the reply is withheld.
                    mem_we <= 1'b0;
                    if (rdw) begin
                        dok     <= 1'b1;
                        ddt     <= 16'h0000;
                        r_state <= S_REPLY_OK;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (!rdr) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 2'd1) begin
                        ddt <= mem_q[0:15];
                        if (w_par_ok) begin
                            dok     <= 1'b1;
                            r_state <= S_REPLY_OK;
                        end else begin
                            dpe     <= 1'b1;
                            r_state <= S_REPLY_PE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_REPLY_OK, S_REPLY_EN, S_REPLY_PE: begin
                    if (!rdr && !rdw) begin
                        dok     <= 1'b0;
                        den     <= 1'b0;
                        dpe     <= 1'b0;
                        ddt     <= 16'h0000;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a behavioural RAM.
// Expected replies are queued when a request is driven and compared
// when the responder raises a reply line.
module tb_mem_responder;
    localparam logic [3:0] MNB = 4'd2;
    localparam int         AW  = 15;
    localparam int         RL  = 2;

    logic          clk_sys = 1'b0;
    logic          clo_n;
    logic          rdr, rdw, rq;
    logic [0:3]    rnb;
    logic [0:15]   rad, rdt;
    logic          dok, den, dpe;
    logic [0:15]   ddt;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [0:16]   mem_d;
    logic [0:16]   mem_q;
    logic          busy;
    logic          flip;

    mem_responder #(
        .MODULE_NB(MNB), .AW(AW), .READ_LATENCY(RL), .PARITY_ODD(1'b1)
    ) dut (
        .clk_sys(clk_sys), .clo_n(clo_n), .rdr(rdr), .rdw(rdw), .rq(rq),
        .rnb(rnb), .rad(rad), .rdt(rdt), .dok(dok), .den(den), .dpe(dpe),
        .ddt(ddt), .mem_a(mem_a), .mem_we(mem_we), .mem_d(mem_d),
        .mem_q(mem_q), .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM: address sampled one edge after it is driven,
    // data visible at the following edge (latency 2).
    logic [0:16] ram [0:(1<<AW)-1];
    logic [0:16] r_p0;
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_a] <= mem_d;
        r_p0 <= ram[mem_a];
    end
    assign mem_q = r_p0 ^ {16'b0, flip};

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Write-strobe monitor and reply one-hot watch.
    int            we_cnt = 0;
    int            hot_viol = 0;
    logic [AW-1:0] we_a;
    logic [0:16]   we_d;
    always @(negedge clk_sys) begin
        if (mem_we) begin
            we_cnt++;
            we_a = mem_a;
            we_d = mem_d;
        end
        if ((32'(dok) + 32'(den) + 32'(dpe)) > 1) hot_viol++;
    end

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] data;
        int          lat;
    } exp_t;
    exp_t sb[$];

    function automatic logic [1:0] reply_kind();
        return dok ? 2'd1 : den ? 2'd2 : dpe ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [16:0] wr_word(input logic [15:0] d);
        logic p;
        p = ($countones(d) % 2 == 0);
        return {d, p};
    endfunction

    // Drive one request, wait for the reply (or its absence), release.
    task automatic xact(input logic r, input logic w, input logic qf,
                        input logic [3:0] nb, input logic [15:0] ad,
                        input logic [15:0] dt, input bit want,
                        input logic [1:0] kind, input logic [15:0] data,
                        input int lat, input string tag);
        exp_t e;
        int   n;
        bit   got;
        rdr = r; rdw = w; rq = qf; rnb = nb; rad = ad; rdt = dt;
        if (want) begin
            e.kind = kind; e.data = data; e.lat = lat;
            sb.push_back(e);
        end
        got = 1'b0;
        n = 0;
        while (n < (want ? 20 : 100) && !got) begin
            @(negedge clk_sys);
            n++;
            if (dok | den | dpe) got = 1'b1;
        end
        if (want) begin
            e = sb.pop_front();
            if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
            chk({tag, "_kind"}, 32'(reply_kind()), 32'(e.kind));
            chk({tag, "_ddt"}, 32'(ddt), 32'(e.data));
            chk({tag, "_lat"}, n, e.lat);
        end else begin
            chk({tag, "_noreply"}, 32'(reply_kind()), 32'd0);
            chk({tag, "_busy"}, 32'(busy), 32'd0);
        end
        rdr = 1'b0; rdw = 1'b0;
        @(negedge clk_sys);
        chk({tag, "_rel"}, {29'd0, dok, den, dpe}, 32'd0);
        chk({tag, "_relddt"}, 32'(ddt), 32'd0);
        chk({tag, "_relbusy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int w0;
        int n;
        logic [15:0] addrs [3];
        logic [15:0] datas [3];
        clo_n = 1'b0; rdr = 1'b0; rdw = 1'b0; rq = 1'b0;
        rnb = 4'd0; rad = 16'h0; rdt = 16'h0; flip = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_reply", {29'd0, dok, den, dpe}, 32'd0);
        chk("rst_ddt", 32'(ddt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_mem_a", 32'(mem_a), 32'd0);
        chk("rst_mem_d", 32'(mem_d), 32'd0);
        clo_n = 1'b1;
        @(negedge clk_sys);

        // Basic write, then read back, then parity-corrupted read.
        w0 = we_cnt;
        xact(0, 1, 1, 4'd2, 16'h0010, 16'h1234, 1, 2'd1, 16'h0, 2, "wr0");
        chk("wr0_wecnt", we_cnt - w0, 1);
        chk("wr0_mem_a", 32'(we_a), 32'h0010);
        chk("wr0_mem_d", 32'(we_d), 32'h02468);
        xact(1, 0, 1, 4'd2, 16'h0010, 16'h0, 1, 2'd1, 16'h1234, RL + 1, "rd0");
        flip = 1'b1;
        xact(1, 0, 1, 4'd2, 16'h0010, 16'h0, 1, 2'd3, 16'h1234, RL + 1, "rdpe");
        flip = 1'b0;

        // Selection: system space always maps to block 0; wrong block ignored.
        w0 = we_cnt;
        xact(0, 1, 0, 4'd2, 16'h0020, 16'h5555, 0, 2'd0, 16'h0, 0, "sysblk");
        xact(0, 1, 1, 4'd3, 16'h0020, 16'h5555, 0, 2'd0, 16'h0, 0, "othblk");
        chk("unsel_wecnt", we_cnt - w0, 0);

        // Out-of-range address and illegal double request.
        w0 = we_cnt;
        xact(1, 0, 1, 4'd2, 16'h8000, 16'h0, 1, 2'd2, 16'h0, 1, "en_rd");
        xact(0, 1, 1, 4'd2, 16'hC000, 16'hBEEF, 1, 2'd2, 16'h0, 1, "en_wr");
        xact(1, 1, 1, 4'd2, 16'h0010, 16'h0, 0, 2'd0, 16'h0, 0, "both");
        chk("en_wecnt", we_cnt - w0, 0);

        // Boundary and random-data round trips.
        addrs[0] = 16'h0000; addrs[1] = 16'h7FFF; addrs[2] = 16'h1555;
        for (int i = 0; i < 3; i++) begin
            datas[i] = 16'($urandom);
            xact(0, 1, 1, 4'd2, addrs[i], datas[i], 1, 2'd1, 16'h0, 2, "wrl");
            chk("wrl_mem_d", 32'(we_d), 32'(wr_word(datas[i])));
            chk("wrl_mem_a", 32'(we_a), 32'(addrs[i][AW-1:0]));
        end
        for (int i = 0; i < 3; i++)
            xact(1, 0, 1, 4'd2, addrs[i], 16'h0, 1, 2'd1, datas[i], RL + 1, "rdl");

        // Read abandoned after one cycle: no reply, back to idle.
        rdr = 1'b1; rq = 1'b1; rnb = 4'd2; rad = 16'h0010;
        @(negedge clk_sys);
        chk("abrd_busy", 32'(busy), 32'd1);
        rdr = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("abrd_reply", {29'd0, dok, den, dpe}, 32'd0);
        chk("abrd_idle", 32'(busy), 32'd0);

        // Write abandoned after one cycle: the strobe still fired.
        w0 = we_cnt;
        rdw = 1'b1; rad = 16'h0030; rdt = 16'h00FF;
        @(negedge clk_sys);
        rdw = 1'b0;
        repeat (5) @(negedge clk_sys);
        chk("abwr_wecnt", we_cnt - w0, 1);
        chk("abwr_reply", {29'd0, dok, den, dpe}, 32'd0);
        chk("abwr_idle", 32'(busy), 32'd0);

        // Asynchronous reset while a reply is held.
        rdw = 1'b1; rad = 16'h0040; rdt = 16'hA5A5;
        n = 0;
        while (!dok && n < 20) begin @(negedge clk_sys); n++; end
        chk("rstrep_dok_seen", 32'(dok), 32'd1);
        clo_n = 1'b0;
        #1;
        chk("rstrep_dok", 32'(dok), 32'd0);
        chk("rstrep_busy", 32'(busy), 32'd0);
        rdw = 1'b0;
        @(negedge clk_sys);
        clo_n = 1'b1;
        @(negedge clk_sys);
        xact(1, 0, 1, 4'd2, 16'h0040, 16'h0, 1, 2'd1, 16'hA5A5, RL + 1, "postrst");

        chk("onehot", hot_viol, 0);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
